// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/WB controller for the 2-bit-opcode core.
// Build option: define ILLEGAL_HALT_EN to trap opcode 2'b10 into HALT instead of treating it as a NOP.
module multicycle_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [1:0]       opcode,
  output logic             ir_load,
  output logic             pc_en,
  output logic             PCsrc,
  output logic             alucntrl,
  output logic             alusrc,
  output logic             immsel,
  output logic             memtoreg,
  output logic             regWrite,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  state_t           state_reg;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] retired_reg;

  assign retired = retired_reg;

  // Outputs decode only registered state and op_q, except ir_load which must
  // follow imem_ack in the same FETCH cycle.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    PCsrc      = 1'b0;
    alucntrl   = 1'b0;
    alusrc     = 1'b0;
    immsel     = 1'b0;
    memtoreg   = 1'b0;
    regWrite   = 1'b0;
    busy       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      DECODE: busy = 1'b1;
      EXEC: begin
        busy = 1'b1;
        case (op_q)
          OP_MOV: memtoreg = 1'b1;
          OP_SLL: begin
            alucntrl = 1'b1;
            alusrc   = 1'b1;
          end
          OP_J: begin
            immsel     = 1'b1;
            PCsrc      = 1'b1;
            pc_en      = 1'b1;
            instr_done = 1'b1;
          end
          default: begin
            illegal = 1'b1;
`ifndef ILLEGAL_HALT_EN
            pc_en      = 1'b1;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      WB: begin
        // Selects stay as in EXEC so the write-back mux sees stable data.
        busy       = 1'b1;
        memtoreg   = (op_q == OP_MOV);
        alucntrl   = (op_q == OP_SLL);
        alusrc     = (op_q == OP_SLL);
        regWrite   = 1'b1;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      HALT: begin
`ifdef ILLEGAL_HALT_EN
        halted = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_q        <= OP_MOV;
      retired_reg <= '0;
    end else begin
      if (instr_done)
        retired_reg <= retired_reg + CNT_W'(1);
      case (state_reg)
        IDLE:   if (start) state_reg <= FETCH;
        FETCH:  if (imem_ack) state_reg <= DECODE;
        DECODE: begin
          op_q      <= opcode;
          state_reg <= EXEC;
        end
        EXEC: begin
          case (op_q)
            OP_J:   state_reg <= stop ? IDLE : FETCH;
            OP_ILL: begin
`ifdef ILLEGAL_HALT_EN
              state_reg <= HALT;
`else
              state_reg <= stop ? IDLE : FETCH;
`endif
            end
            default: state_reg <= WB;
          endcase
        end
        WB: state_reg <= stop ? IDLE : FETCH;
        HALT: begin
`ifdef ILLEGAL_HALT_EN
          state_reg <= HALT;
`else
          state_reg <= IDLE;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer (counter width 4 so wrap-around is reachable).
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       imem_ack = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic       imem_req, ir_load, pc_en, PCsrc, alucntrl, alusrc, immsel;
  logic       memtoreg, regWrite, busy, instr_done, illegal, halted;
  logic [3:0] retired;

  int total = 0;
  int bad = 0;
  int n_req, n_irload, n_regwrite, n_pcsrc, n_overlap, n_illegal;

  multicycle_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .imem_req(imem_req), .imem_ack(imem_ack), .opcode(opcode),
    .ir_load(ir_load), .pc_en(pc_en), .PCsrc(PCsrc), .alucntrl(alucntrl),
    .alusrc(alusrc), .immsel(immsel), .memtoreg(memtoreg), .regWrite(regWrite),
    .busy(busy), .instr_done(instr_done), .illegal(illegal), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] all_outs();
    return {imem_req, ir_load, pc_en, PCsrc, alucntrl, alusrc, immsel,
            memtoreg, regWrite, busy, instr_done, illegal, halted};
  endfunction

  // Expected {alucntrl, alusrc, immsel, memtoreg, regWrite, PCsrc, pc_en} at retirement
  localparam logic [6:0] SEL_MOV = 7'b0001101;
  localparam logic [6:0] SEL_SLL = 7'b1100101;
  localparam logic [6:0] SEL_J   = 7'b0010011;
  localparam logic [6:0] SEL_NOP = 7'b0000001;

  // Called at a negedge with the DUT in its first FETCH cycle; returns at the
  // negedge after retirement (or immediately once HALT is seen).
  task automatic exec_instr(input logic [1:0] op, input int ack_delay, input logic stop_req,
                            output int done_cyc, output logic [6:0] sel);
    done_cyc = 0;
    sel = '0;
    n_req = 0; n_irload = 0; n_regwrite = 0; n_pcsrc = 0; n_overlap = 0; n_illegal = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (imem_req && cyc > ack_delay) begin
        imem_ack = 1'b1;
        opcode = op;
      end else begin
        imem_ack = 1'b0;
      end
      #1;
      if (imem_req) n_req++;
      if (ir_load) n_irload++;
      if (regWrite) n_regwrite++;
      if (PCsrc) n_pcsrc++;
      if (imem_req && pc_en) n_overlap++;
      if (illegal) n_illegal++;
      if (instr_done) begin
        done_cyc = cyc;
        sel = {alucntrl, alusrc, immsel, memtoreg, regWrite, PCsrc, pc_en};
        stop = stop_req;
      end
      if (halted) break;
      @(posedge clk);
      @(negedge clk);
      if (done_cyc != 0) break;
    end
    imem_ack = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (all_outs() !== 13'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want %b", all_outs(), 13'b0);
    end
    total++;
    if (retired !== 4'd0) begin
      bad++;
      $display("FAIL reset_retired: got %0d want 0", retired);
    end
    rst = 1'b0;
    $display("reset: outs=%b retired=%0d", all_outs(), retired);
  endtask

  task automatic test_program();
    int dc;
    int base;
    int rw;
    logic [6:0] sel;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    base = 0;
    rw = 0;
    exec_instr(2'b00, 0, 1'b0, dc, sel);
    base += dc;
    rw += n_regwrite;
    total++;
    if (base !== 4 || sel !== SEL_MOV || n_pcsrc !== 0) begin
      bad++;
      $display("FAIL prog_mov: done=%0d sel=%b pcsrc=%0d want done=4 sel=%b pcsrc=0", base, sel, n_pcsrc, SEL_MOV);
    end
    $display("MOV: done at %0d sel=%b", base, sel);
    exec_instr(2'b01, 0, 1'b0, dc, sel);
    base += dc;
    rw += n_regwrite;
    total++;
    if (base !== 8 || sel !== SEL_SLL || n_pcsrc !== 0) begin
      bad++;
      $display("FAIL prog_sll: done=%0d sel=%b pcsrc=%0d want done=8 sel=%b pcsrc=0", base, sel, n_pcsrc, SEL_SLL);
    end
    $display("SLL: done at %0d sel=%b", base, sel);
    exec_instr(2'b11, 0, 1'b0, dc, sel);
    base += dc;
    rw += n_regwrite;
    total++;
    if (base !== 11 || sel !== SEL_J || n_pcsrc !== 1 || n_overlap !== 0) begin
      bad++;
      $display("FAIL prog_j: done=%0d sel=%b pcsrc=%0d overlap=%0d want done=11 sel=%b pcsrc=1 overlap=0",
               base, sel, n_pcsrc, n_overlap, SEL_J);
    end
    $display("J: done at %0d sel=%b", base, sel);
    total++;
    if (rw !== 2 || retired !== 4'd3) begin
      bad++;
      $display("FAIL prog_totals: regwrite=%0d retired=%0d want regwrite=2 retired=3", rw, retired);
    end
  endtask

  task automatic test_ack_delay();
    int dc;
    logic [6:0] sel;
    exec_instr(2'b00, 5, 1'b0, dc, sel);
    total++;
    if (dc !== 9 || n_req !== 6 || n_irload !== 1 || sel !== SEL_MOV) begin
      bad++;
      $display("FAIL ack_delay: done=%0d req=%0d irload=%0d sel=%b want 9 6 1 %b", dc, n_req, n_irload, sel, SEL_MOV);
    end
    total++;
    if (retired !== 4'd4) begin
      bad++;
      $display("FAIL ack_delay_retired: got %0d want 4", retired);
    end
    $display("ack delay 5: done at %0d req cycles=%0d", dc, n_req);
  endtask

  task automatic test_stop();
    int dc;
    logic [6:0] sel;
    exec_instr(2'b01, 0, 1'b1, dc, sel);
    total++;
    if (dc !== 4 || sel !== SEL_SLL) begin
      bad++;
      $display("FAIL stop_sll: done=%0d sel=%b want 4 %b", dc, sel, SEL_SLL);
    end
    total++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || retired !== 4'd5) begin
      bad++;
      $display("FAIL stop_idle: busy=%b req=%b retired=%0d want 0 0 5", busy, imem_req, retired);
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (imem_req !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart: req=%b busy=%b want 1 1", imem_req, busy);
    end
    $display("stop: done at %0d then restart req=%b", dc, imem_req);
  endtask

  task automatic test_illegal();
    int dc;
    int viol;
    logic [6:0] sel;
    exec_instr(2'b10, 0, 1'b0, dc, sel);
    total++;
    if (n_illegal !== 1) begin
      bad++;
      $display("FAIL illegal_pulse: got %0d pulses want 1", n_illegal);
    end
`ifdef ILLEGAL_HALT_EN
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || pc_en !== 1'b0 || busy !== 1'b0 || instr_done !== 1'b0) viol++;
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (viol !== 0 || retired !== 4'd5) begin
      bad++;
      $display("FAIL halt_hold: bad cycles=%0d retired=%0d want 0 5", viol, retired);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (halted !== 1'b0 || all_outs() !== 13'b0) begin
      bad++;
      $display("FAIL halt_reset: outs=%b want 0", all_outs());
    end
    $display("illegal: halted held, cleared by rst");
`else
    viol = 0;
    total++;
    if (dc !== 3 || sel !== SEL_NOP || retired !== 4'd6) begin
      bad++;
      $display("FAIL illegal_nop: done=%0d sel=%b retired=%0d want 3 %b 6", dc, sel, retired, SEL_NOP);
    end
    total++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || viol !== 0) begin
      bad++;
      $display("FAIL illegal_next: halted=%b req=%b want 0 1", halted, imem_req);
    end
    $display("illegal: NOP retired at %0d retired=%0d", dc, retired);
`endif
  endtask

  task automatic test_wrap();
    int dc;
    int late;
    logic [6:0] sel;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    late = 0;
    for (int i = 0; i < 15; i++) begin
      exec_instr(2'b11, 0, 1'b0, dc, sel);
      if (dc !== 3) late++;
    end
    total++;
    if (retired !== 4'd15 || late !== 0) begin
      bad++;
      $display("FAIL wrap_preload: retired=%0d off-latency=%0d want 15 0", retired, late);
    end
    exec_instr(2'b11, 0, 1'b0, dc, sel);
    total++;
    if (retired !== 4'd0) begin
      bad++;
      $display("FAIL wrap: retired=%0d want 0", retired);
    end
    $display("wrap: retired=%0d", retired);
  endtask

  task automatic test_rst_fetch();
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_fetch_pre: req=%b want 1", imem_req);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    opcode = 2'b01;
    #1;
    total++;
    if (all_outs() !== 13'b0) begin
      bad++;
      $display("FAIL rst_fetch_outs: got %b want %b", all_outs(), 13'b0);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || ir_load !== 1'b0 || retired !== 4'd0) begin
      bad++;
      $display("FAIL late_ack: busy=%b req=%b irload=%b retired=%0d want 0 0 0 0", busy, imem_req, ir_load, retired);
    end
    imem_ack = 1'b0;
    $display("rst in FETCH: outs=%b", all_outs());
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_program();
    test_ack_delay();
    test_stop();
    test_illegal();
    test_wrap();
    test_rst_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
